// File: rtl/uart_io_ctrl_pkg.sv
// Shared definitions for the UART memory-mapped I/O controller: address map,
// opcodes, status bit positions and the TX drain state encoding.
package uart_io_ctrl_pkg;

   localparam logic [23:0] IO_BASE = 24'hFFFF00;

   // Word offsets (byte offset >> 2)
   localparam logic [5:0] OFF_TXSTAT = 6'h00;
   localparam logic [5:0] OFF_RXSTAT = 6'h01;
   localparam logic [5:0] OFF_TXDATA = 6'h02;
   localparam logic [5:0] OFF_RXDATA = 6'h03;
   localparam logic [5:0] OFF_CYCLES = 6'h04;

   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SW  = 6'h2B;

   localparam int STAT_AVAIL_BIT = 0;
   localparam int STAT_OVF_BIT   = 1;

   typedef enum logic {
      TX_IDLE = 1'b0,
      TX_SEND = 1'b1
   } txState_t;

   function automatic logic isLoadOp(input logic [5:0] op);
      case (op)
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: isLoadOp = 1'b1;
         default:                             isLoadOp = 1'b0;
      endcase
   endfunction

   function automatic logic isStoreOp(input logic [5:0] op);
      case (op)
         OP_SB, OP_SH, OP_SW: isStoreOp = 1'b1;
         default:             isStoreOp = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/uart_io_ctrl_if.sv
// UART-side valid/ready handshakes: TX toward the UART, RX from the UART.
interface uart_io_ctrl_if;
   logic       DataInValid;
   logic [7:0] UARTDataIn;
   logic       DataInReady;
   logic       DataOutValid;
   logic [7:0] UARTDataOut;
   logic       DataOutReady;

   modport master (
      output DataInValid, UARTDataIn, DataOutReady,
      input  DataInReady, DataOutValid, UARTDataOut
   );

   modport slave (
      input  DataInValid, UARTDataIn, DataOutReady,
      output DataInReady, DataOutValid, UARTDataOut
   );
endinterface

// File: rtl/uart_io_ctrl_sync_fifo.sv
// Synchronous FIFO with combinational head. A push while full is accepted only
// when a valid pop happens in the same cycle; a pop while empty is ignored.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [WIDTH-1:0] memR [DEPTH];
   logic [AW-1:0]    wrPtrR;
   logic [AW-1:0]    rdPtrR;
   logic [AW:0]      cntR;
   logic             doPushS;
   logic             doPopS;

   assign doPopS  = pop && !empty;
   assign doPushS = push && (!full || doPopS);
   assign full    = (cntR == FULL_CNT);
   assign empty   = (cntR == {(AW+1){1'b0}});
   assign count   = cntR;
   assign dout    = memR[rdPtrR];

   // Storage array, written on accepted push
   always_ff @(posedge clk) begin
      if (doPushS) begin
         memR[wrPtrR] <= din;
      end
   end

   // Pointers and occupancy; power-of-two depth lets pointers wrap naturally
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wrPtrR <= {AW{1'b0}};
         rdPtrR <= {AW{1'b0}};
         cntR   <= {(AW+1){1'b0}};
      end else begin
         if (doPushS) begin
            wrPtrR <= wrPtrR + 1'b1;
         end
         if (doPopS) begin
            rdPtrR <= rdPtrR + 1'b1;
         end
         case ({doPushS, doPopS})
            2'b10:   cntR <= cntR + 1'b1;
            2'b01:   cntR <= cntR - 1'b1;
            default: cntR <= cntR;
         endcase
      end
   end
endmodule

// File: rtl/uart_io_ctrl.sv
// Memory-mapped UART controller: decodes E-stage I/O loads/stores, buffers TX/RX
// bytes, drains TX to the UART and returns load data aligned to the M stage.
module uart_io_ctrl
   import uart_io_ctrl_pkg::*;
#(
   parameter int TX_DEPTH = 8,
   parameter int RX_DEPTH = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              stall,
   input  logic [5:0]        opcodeE,
   input  logic [31:0]       ALUOutE,
   input  logic [31:0]       rd2E,
   output logic              ioSelE,
   output logic              UARTCtr,
   output logic [31:0]       UARTCtrOut,
   uart_io_ctrl_if.master    uart
);
   localparam int TXCW = $clog2(TX_DEPTH) + 1;
   localparam int RXCW = $clog2(RX_DEPTH) + 1;
   localparam logic [TXCW-1:0] TX_ONE = {{(TXCW-1){1'b0}}, 1'b1};

   txState_t        txStateR, txStateNextS;
   logic            isLoadS, isStoreS, ioLoadS, ioStoreS;
   logic [5:0]      wordOffS;
   logic            txPushReqS, txPopS, txFullS, txEmptyS, txOvfSetS;
   logic [7:0]      txHeadS;
   logic [TXCW-1:0] txCountS;
   logic            rxPushS, rxPopS, rxFullS, rxEmptyS, rxOvfSetS;
   logic [7:0]      rxHeadS;
   logic [RXCW-1:0] rxCountS;
   logic            txOvfR, rxOvfR;
   logic [31:0]     cycleR;
   logic [31:0]     loadDataS;
   logic            unusedOk;

   assign isLoadS  = isLoadOp(opcodeE);
   assign isStoreS = isStoreOp(opcodeE);
   assign ioSelE   = (isLoadS || isStoreS) && (ALUOutE[31:8] == IO_BASE);
   assign ioLoadS  = ioSelE && !stall && isLoadS;
   assign ioStoreS = ioSelE && !stall && isStoreS;
   assign wordOffS = ALUOutE[7:2];

   assign txPushReqS = ioStoreS && (wordOffS == OFF_TXDATA);
   assign txPopS     = (txStateR == TX_SEND) && uart.DataInReady;
   assign txOvfSetS  = txPushReqS && txFullS && !txPopS;

   assign uart.DataOutReady = reset_n && !rxFullS;
   assign rxPushS   = uart.DataOutValid && uart.DataOutReady;
   assign rxPopS    = ioLoadS && (wordOffS == OFF_RXDATA);
   assign rxOvfSetS = uart.DataOutValid && rxFullS;

   assign uart.DataInValid = (txStateR == TX_SEND);
   assign uart.UARTDataIn  = (txStateR == TX_SEND) ? txHeadS : 8'h00;

   assign unusedOk = ^{ALUOutE[1:0], rd2E[31:8], rxCountS};

   sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) txFifo (
      .clk(clk), .reset_n(reset_n), .push(txPushReqS), .pop(txPopS),
      .din(rd2E[7:0]), .dout(txHeadS), .full(txFullS), .empty(txEmptyS),
      .count(txCountS)
   );

   sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) rxFifo (
      .clk(clk), .reset_n(reset_n), .push(rxPushS), .pop(rxPopS),
      .din(uart.UARTDataOut), .dout(rxHeadS), .full(rxFullS), .empty(rxEmptyS),
      .count(rxCountS)
   );

   // TX drain state register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         txStateR <= TX_IDLE;
      end else begin
         txStateR <= txStateNextS;
      end
   end

   // TX drain next state: leave SEND only when the last byte is handed over
   always_comb begin
      txStateNextS = txStateR;
      case (txStateR)
         TX_IDLE: begin
            if (!txEmptyS) txStateNextS = TX_SEND;
            else           txStateNextS = TX_IDLE;
         end
         TX_SEND: begin
            if (txPopS && (txCountS == TX_ONE) && !txPushReqS) txStateNextS = TX_IDLE;
            else                                                txStateNextS = TX_SEND;
         end
         default: txStateNextS = TX_IDLE;
      endcase
   end

   // Sticky overflow flags; a new overflow beats a simultaneous clear
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         txOvfR <= 1'b0;
         rxOvfR <= 1'b0;
      end else begin
         if (txOvfSetS)
            txOvfR <= 1'b1;
         else if (ioStoreS && (wordOffS == OFF_TXSTAT) && rd2E[STAT_OVF_BIT])
            txOvfR <= 1'b0;
         else
            txOvfR <= txOvfR;
         if (rxOvfSetS)
            rxOvfR <= 1'b1;
         else if (ioStoreS && (wordOffS == OFF_RXSTAT) && rd2E[STAT_OVF_BIT])
            rxOvfR <= 1'b0;
         else
            rxOvfR <= rxOvfR;
      end
   end

   // Free-running cycle counter; counts through stalls, store clears
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cycleR <= 32'h0000_0000;
      end else if (ioStoreS && (wordOffS == OFF_CYCLES)) begin
         cycleR <= 32'h0000_0000;
      end else begin
         cycleR <= cycleR + 32'h0000_0001;
      end
   end

   // Load-data read mux
   always_comb begin
      loadDataS = 32'h0000_0000;
      case (wordOffS)
         OFF_TXSTAT: loadDataS = {30'b0, txOvfR, !txFullS};
         OFF_RXSTAT: loadDataS = {30'b0, rxOvfR, !rxEmptyS};
         OFF_RXDATA: loadDataS = rxEmptyS ? 32'h0000_0000 : {24'h000000, rxHeadS};
         OFF_CYCLES: loadDataS = cycleR;
         default:    loadDataS = 32'h0000_0000;
      endcase
   end

   // M-stage writeback registers, frozen while stalled
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         UARTCtr    <= 1'b0;
         UARTCtrOut <= 32'h0000_0000;
      end else if (!stall) begin
         UARTCtr <= ioLoadS;
         if (ioLoadS) UARTCtrOut <= loadDataS;
         else         UARTCtrOut <= UARTCtrOut;
      end else begin
         UARTCtr    <= UARTCtr;
         UARTCtrOut <= UARTCtrOut;
      end
   end
endmodule

// File: tb/tb_uart_io_ctrl.sv
// Directed self-checking bench for uart_io_ctrl.
module tb_uart_io_ctrl;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        stall;
   logic [5:0]  opcodeE;
   logic [31:0] ALUOutE;
   logic [31:0] rd2E;
   logic        ioSelE;
   logic        UARTCtr;
   logic [31:0] UARTCtrOut;
   int          checks = 0;
   int          errors = 0;

   uart_io_ctrl_if uif();

   uart_io_ctrl #(.TX_DEPTH(8), .RX_DEPTH(8)) dut (
      .clk(clk), .reset_n(reset_n), .stall(stall), .opcodeE(opcodeE),
      .ALUOutE(ALUOutE), .rd2E(rd2E), .ioSelE(ioSelE), .UARTCtr(UARTCtr),
      .UARTCtrOut(UARTCtrOut), .uart(uif)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idleBus();
      opcodeE = 6'h00;
      ALUOutE = 32'h0000_0000;
      rd2E    = 32'h0000_0000;
   endtask

   task automatic sw(input logic [7:0] off, input logic [31:0] data);
      opcodeE = 6'h2B;
      ALUOutE = {24'hFFFF00, off};
      rd2E    = data;
      tick();
      idleBus();
   endtask

   task automatic readChk(input string tag, input logic [7:0] off, input logic [31:0] exp);
      opcodeE = 6'h23;
      ALUOutE = {24'hFFFF00, off};
      tick();
      idleBus();
      chk({tag, "_ctr"}, {31'b0, UARTCtr}, 32'h1);
      chk(tag, UARTCtrOut, exp);
   endtask

   initial begin
      logic [7:0] txExp [3];
      txExp[0] = 8'h41; txExp[1] = 8'h42; txExp[2] = 8'h43;
      reset_n = 1'b0; stall = 1'b0; idleBus();
      uif.DataInReady = 1'b0; uif.DataOutValid = 1'b0; uif.UARTDataOut = 8'h00;
      repeat (3) tick();
      chk("rst_valid", {31'b0, uif.DataInValid}, 32'h0);
      chk("rst_rxready", {31'b0, uif.DataOutReady}, 32'h0);
      chk("rst_ctr", {31'b0, UARTCtr}, 32'h0);
      chk("rst_out", UARTCtrOut, 32'h0);
      reset_n = 1'b1;
      #1;
      chk("rxready_after_rst", {31'b0, uif.DataOutReady}, 32'h1);

      // Decode: I/O store hits, same opcode elsewhere and non-memory opcode miss
      opcodeE = 6'h2B; ALUOutE = 32'hFFFF_0008; #1;
      chk("iosel_hit", {31'b0, ioSelE}, 32'h1);
      ALUOutE = 32'hFFFF_0108; #1;
      chk("iosel_miss_addr", {31'b0, ioSelE}, 32'h0);
      opcodeE = 6'h08; ALUOutE = 32'hFFFF_0008; #1;
      chk("iosel_miss_op", {31'b0, ioSelE}, 32'h0);
      idleBus();

      // TX drain with slow UART
      sw(8'h08, 32'h41); sw(8'h08, 32'h42); sw(8'h08, 32'h43);
      for (int b = 0; b < 3; b++) begin
         for (int w = 0; w < 4; w++) begin
            chk("tx_valid_held", {31'b0, uif.DataInValid}, 32'h1);
            chk("tx_data_held", {24'h0, uif.UARTDataIn}, {24'h0, txExp[b]});
            tick();
         end
         uif.DataInReady = 1'b1;
         tick();
         uif.DataInReady = 1'b0;
      end
      chk("tx_idle_after_drain", {31'b0, uif.DataInValid}, 32'h0);

      // Reset in the middle of a send
      sw(8'h08, 32'h55);
      tick();
      chk("midsend_valid", {31'b0, uif.DataInValid}, 32'h1);
      reset_n = 1'b0;
      repeat (3) begin
         tick();
         chk("midrst_valid", {31'b0, uif.DataInValid}, 32'h0);
         chk("midrst_data", {24'h0, uif.UARTDataIn}, 32'h0);
      end
      reset_n = 1'b1;
      readChk("cycles_restart", 8'h10, 32'h0);
      readChk("txstat_after_rst", 8'h00, 32'h1);
      tick();
      chk("tx_abandoned", {31'b0, uif.DataInValid}, 32'h0);

      // TX overflow: nine stores into eight entries
      for (int i = 0; i < 9; i++) sw(8'h08, 32'h10 + i);
      readChk("txstat_full_ovf", 8'h00, 32'h2);
      uif.DataInReady = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("ovf_drain_valid", {31'b0, uif.DataInValid}, 32'h1);
         chk("ovf_drain_data", {24'h0, uif.UARTDataIn}, 32'h10 + i);
         tick();
      end
      uif.DataInReady = 1'b0;
      chk("ovf_drain_done", {31'b0, uif.DataInValid}, 32'h0);
      sw(8'h00, 32'h2);
      readChk("txstat_cleared", 8'h00, 32'h1);

      // RX single byte
      uif.DataOutValid = 1'b1; uif.UARTDataOut = 8'h5A;
      tick();
      uif.DataOutValid = 1'b0;
      readChk("rx_data", 8'h0C, 32'h5A);
      readChk("rx_empty_read", 8'h0C, 32'h0);
      readChk("rxstat_empty", 8'h04, 32'h0);
      tick();
      chk("ctr_drops", {31'b0, UARTCtr}, 32'h0);

      // Simultaneous RX push and CPU pop at count 1, then stalled load
      uif.DataOutValid = 1'b1; uif.UARTDataOut = 8'h11;
      tick();
      uif.UARTDataOut = 8'h22;
      opcodeE = 6'h23; ALUOutE = 32'hFFFF_000C;
      tick();
      uif.DataOutValid = 1'b0; idleBus();
      chk("pushpop_data", UARTCtrOut, 32'h11);
      readChk("pushpop_stat", 8'h04, 32'h1);
      stall = 1'b1;
      opcodeE = 6'h23; ALUOutE = 32'hFFFF_000C;
      tick(); tick();
      chk("stall_ctr", {31'b0, UARTCtr}, 32'h1);
      chk("stall_out", UARTCtrOut, 32'h1);
      stall = 1'b0;
      tick();
      idleBus();
      chk("after_stall_data", UARTCtrOut, 32'h22);
      readChk("pushpop_count1", 8'h0C, 32'h0);

      // RX fill to full and overflow
      uif.DataOutValid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         uif.UARTDataOut = 8'hA0 + 8'(i);
         tick();
      end
      chk("rx_full_ready", {31'b0, uif.DataOutReady}, 32'h0);
      tick();
      uif.DataOutValid = 1'b0;
      readChk("rxstat_full_ovf", 8'h04, 32'h3);
      sw(8'h04, 32'h2);
      readChk("rxstat_cleared", 8'h04, 32'h1);
      readChk("rx_fill_first", 8'h0C, 32'hA0);
      readChk("rx_fill_second", 8'h0C, 32'hA1);
      readChk("unmapped_read", 8'h14, 32'h0);

      // Cycle counter wrap and clear
      force dut.cycleR = 32'hFFFF_FFFE;
      #1;
      release dut.cycleR;
      readChk("cyc_fffe", 8'h10, 32'hFFFF_FFFE);
      readChk("cyc_ffff", 8'h10, 32'hFFFF_FFFF);
      readChk("cyc_wrap", 8'h10, 32'h0);
      sw(8'h10, 32'h0);
      readChk("cyc_clear", 8'h10, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
